// File: rtl/prefix_adder_wrapper_checker.sv
// prefix_adder_wrapper_checker: drives a/b vectors into a registered adder wrapper and checks sum/cout against a+b
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 one-cycle pulse that begins a run (ignored while busy)
//   a_out, b_out          registered operands to the adder under test
//   sum_in, cout_in       adder result, expected LATENCY cycles after the operands
//   busy, done, pass      run status; pass is meaningful while done is high
//   err_count, vec_count  mismatching results (saturating) and results checked
//   first_fail_idx        vector index of the first mismatch, 16'hFFFF if none
module prefix_adder_wrapper_checker #(
  parameter int          WIDTH       = 16,
  parameter int          LATENCY     = 2,
  parameter int          NUM_VECTORS = 1024,
  parameter logic [31:0] SEED_A      = 32'h1,
  parameter logic [31:0] SEED_B      = 32'h2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             cout_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      vec_count,
  output logic [15:0]      first_fail_idx
);
  localparam int          W1   = WIDTH + 1;
  localparam logic [31:0] SA   = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
  localparam logic [31:0] SB   = (SEED_B == 32'h0) ? 32'h1 : SEED_B;
  localparam logic [15:0] LAST = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] NONE = 16'hFFFF;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, w_a, w_b;
  logic [31:0]      r_lfsr_a, r_lfsr_b, w_step_a, w_step_b;
  logic [15:0]      r_idx, r_iidx, w_idx;
  logic             r_iv;
  logic [LATENCY-1:0] r_dv;
  logic [15:0]      r_didx [LATENCY];
  logic [W1-1:0]    r_dexp [LATENCY];
  logic [W1-1:0]    w_exp;
  logic [15:0]      r_err, r_vec, r_ffi;
  logic             r_done, r_pass;
  logic             w_go, w_issue, w_empty, w_pop, w_bad;
  function automatic logic [31:0] f_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction
  // r_iv/r_iidx travel with the registered operands, so the delay line starts
  // one cycle after issue and LATENCY stages land the pop on the right result.
  always_comb begin
    w_go     = start && (r_state == IDLE || r_state == DONE);
    w_issue  = w_go || r_state == RUN;
    w_idx    = w_go ? 16'd0 : r_idx;
    w_step_a = f_step(r_lfsr_a);
    w_step_b = f_step(r_lfsr_b);
    w_a      = (w_idx < 16'd2) ? '1 : (w_idx == 16'd2) ? '0 : w_step_a[WIDTH-1:0];
    w_b      = (w_idx == 16'd0) ? WIDTH'(1) : (w_idx == 16'd1) ? '1 :
               (w_idx == 16'd2) ? '0 : w_step_b[WIDTH-1:0];
    w_exp    = {1'b0, r_a} + {1'b0, r_b};
    w_empty  = !r_iv && r_dv == '0;
    w_pop    = r_dv[LATENCY-1];
    w_bad    = w_pop && ({cout_in, sum_in} != r_dexp[LATENCY-1]);
    w_next   = w_go ? RUN :
               (r_state == RUN && w_idx == LAST) ? DRAIN :
               (r_state == DRAIN && w_empty) ? DONE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_lfsr_a <= SA;
      r_lfsr_b <= SB;
      r_idx    <= '0;
      r_iidx   <= '0;
      r_iv     <= 1'b0;
      r_dv     <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_didx[k] <= '0;
        r_dexp[k] <= '0;
      end
      r_err    <= '0;
      r_vec    <= '0;
      r_ffi    <= NONE;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_iv    <= w_issue;
      if (w_issue) begin
        r_a    <= w_a;
        r_b    <= w_b;
        r_iidx <= w_idx;
        r_idx  <= w_idx + 16'd1;
      end
      // LFSRs step only for pseudo-random vectors, so vector 3 is the first step from the seed
      if (w_go) begin
        r_lfsr_a <= SA;
        r_lfsr_b <= SB;
      end else if (w_issue && w_idx > 16'd2) begin
        r_lfsr_a <= w_step_a;
        r_lfsr_b <= w_step_b;
      end
      r_dv[0]   <= r_iv;
      r_didx[0] <= r_iidx;
      r_dexp[0] <= w_exp;
      for (int k = 1; k < LATENCY; k++) begin
        r_dv[k]   <= r_dv[k-1];
        r_didx[k] <= r_didx[k-1];
        r_dexp[k] <= r_dexp[k-1];
      end
      if (w_go) begin
        r_err  <= '0;
        r_vec  <= '0;
        r_ffi  <= NONE;
        r_done <= 1'b0;
        r_pass <= 1'b0;
      end else begin
        if (w_pop) r_vec <= r_vec + 16'd1;
        if (w_bad && r_err != 16'hFFFF) r_err <= r_err + 16'd1;
        if (w_bad && r_ffi == NONE) r_ffi <= r_didx[LATENCY-1];
        if (r_state == DRAIN && w_empty) begin
          r_done <= 1'b1;
          r_pass <= r_err == 16'd0;
        end
      end
    end
  end
  assign a_out          = r_a;
  assign b_out          = r_b;
  assign busy           = r_state == RUN || r_state == DRAIN;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign vec_count      = r_vec;
  assign first_fail_idx = r_ffi;
endmodule
